sequencia_controle: RTL and testbench

//  Round-based sequence controller. Sits directly upstream of the 16x4 synchronous pattern ROM.

---
 rtl/sequencia_controle.sv | 103 ++++++++++
 tb/tb_sequencia_controle.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencia_controle.sv
// sequencia_controle: round-based sequence controller that reads a registered pattern ROM and checks player moves
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   iniciar      in   start/restart request (IDLE, GANHOU, PERDEU only)
//   jogada       in   player move, qualified by jogada_valid
//   jogada_valid in   one-clock strobe, honoured only in ESPERA
//   rom_data     in   ROM data_out, valid one clock after rom_address changes
//   rom_address  out  ROM address
//   esperando    out  high while a move is accepted
//   rodada       out  current round index
//   fim_rodada   out  one-clock pulse when a non-final round completes
//   ganhou       out  high after the last round is completed
//   perdeu       out  high after a wrong move or a timeout
//   timeout      out  high with perdeu when the loss came from a timeout
module sequencia_controle #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4,
    parameter int LAST_ROUND  = 15,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] jogada,
    input  logic              jogada_valid,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic              esperando,
    output logic [ADDR_W-1:0] rodada,
    output logic              fim_rodada,
    output logic              ganhou,
    output logic              perdeu,
    output logic              timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ROUND);
    typedef enum logic [2:0] {IDLE, BUSCA, CARREGA, ESPERA, GANHOU, PERDEU} state_t;
    state_t state;
    logic [DATA_W-1:0] esperado;
    logic [CNT_W-1:0] contador;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            esperado    <= '0;
            contador    <= '0;
            rom_address <= '0;
            rodada      <= '0;
            esperando   <= 1'b0;
            fim_rodada  <= 1'b0;
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            fim_rodada <= 1'b0;
            case (state)
                IDLE, GANHOU, PERDEU: if (iniciar) begin
                    state       <= BUSCA;
                    rodada      <= '0;
                    rom_address <= '0;
                    ganhou      <= 1'b0;
                    perdeu      <= 1'b0;
                    timeout     <= 1'b0;
                end
                // the ROM samples rom_address on this edge; data is ready for CARREGA
                BUSCA: state <= CARREGA;
                CARREGA: begin
                    esperado  <= rom_data;
                    contador  <= '0;
                    esperando <= 1'b1;
                    state     <= ESPERA;
                end
                // a strobe wins over a timeout landing on the same cycle
                ESPERA: if (jogada_valid) begin
                    esperando <= 1'b0;
                    if (jogada != esperado) begin
                        state  <= PERDEU;
                        perdeu <= 1'b1;
                    end else if (rom_address < rodada) begin
                        rom_address <= rom_address + 1'b1;
                        state       <= BUSCA;
                    end else if (rodada == LAST) begin
                        state  <= GANHOU;
                        ganhou <= 1'b1;
                    end else begin
                        fim_rodada  <= 1'b1;
                        rodada      <= rodada + 1'b1;
                        rom_address <= '0;
                        state       <= BUSCA;
                    end
                end else if (contador == CNT_LAST) begin
                    esperando <= 1'b0;
                    state     <= PERDEU;
                    perdeu    <= 1'b1;
                    timeout   <= 1'b1;
                end else begin
                    contador <= contador + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequencia_controle.sv
// tb_sequencia_controle: directed test of sequencia_controle against a round/position model and a registered ROM
module tb_sequencia_controle;
    localparam int LAST_ROUND  = 3;
    localparam int TIMEOUT_CYC = 12;
    localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_WON = 3, P_LOST = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] jogada = 4'h0;
    logic       jogada_valid = 1'b0;
    logic [3:0] rom_data = 4'h0;
    logic [3:0] rom_address;
    logic       esperando;
    logic [3:0] rodada;
    logic       fim_rodada;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    sequencia_controle #(
        .ADDR_W(4), .DATA_W(4), .LAST_ROUND(LAST_ROUND), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .jogada_valid(jogada_valid), .rom_data(rom_data), .rom_address(rom_address),
        .esperando(esperando), .rodada(rodada), .fim_rodada(fim_rodada),
        .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom_address ^ 4'hA;

    function automatic logic [3:0] pattern(input int a);
        return 4'(a) ^ 4'hA;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: which sequence position is being asked for, how far the player got, and how long it has waited
    int m_phase = P_IDLE;
    int m_fetch = 0;
    int m_wait  = 0;
    int m_round = 0;
    int m_pos   = 0;
    bit m_fim   = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE;
            m_fetch = 0;
            m_wait  = 0;
            m_round = 0;
            m_pos   = 0;
            m_fim   = 1'b0;
            m_to    = 1'b0;
        end else begin
            m_fim = 1'b0;
            if (m_phase == P_IDLE || m_phase == P_WON || m_phase == P_LOST) begin
                if (iniciar) begin
                    m_phase = P_FETCH;
                    m_fetch = 2;
                    m_round = 0;
                    m_pos   = 0;
                    m_to    = 1'b0;
                end
            end else if (m_phase == P_FETCH) begin
                m_fetch--;
                if (m_fetch == 0) begin
                    m_phase = P_WAIT;
                    m_wait  = 0;
                end
            end else if (jogada_valid) begin
                if (jogada != pattern(m_pos)) begin
                    m_phase = P_LOST;
                end else if (m_pos < m_round) begin
                    m_pos++;
                    m_phase = P_FETCH;
                    m_fetch = 2;
                end else if (m_round == LAST_ROUND) begin
                    m_phase = P_WON;
                end else begin
                    m_fim   = 1'b1;
                    m_round++;
                    m_pos   = 0;
                    m_phase = P_FETCH;
                    m_fetch = 2;
                end
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT_CYC) begin
                    m_phase = P_LOST;
                    m_to    = 1'b1;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (reset) begin
            chk("rom_address", rom_address, 32'(m_pos));
            chk("esperando", esperando, m_phase == P_WAIT);
            chk("rodada", rodada, 32'(m_round));
            chk("fim_rodada", fim_rodada, m_fim);
            chk("ganhou", ganhou, m_phase == P_WON);
            chk("perdeu", perdeu, m_phase == P_LOST);
            chk("timeout", timeout, m_to);
        end
    end

    task automatic start();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic move(input logic [3:0] v);
        jogada       = v;
        jogada_valid = 1'b1;
        @(negedge clock);
        jogada_valid = 1'b0;
    endtask

    task automatic wait_esp();
        int n = 0;
        while (!esperando && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!esperando) begin
            checks++;
            errors++;
            $display("FAIL wait_esperando: got 0 expected 1 within 20 clocks at %0t", $time);
        end
    endtask

    task automatic play_round(input int r);
        for (int i = 0; i <= r; i++) begin
            wait_esp();
            move(pattern(i));
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_outputs", {rom_address, esperando, rodada, fim_rodada, ganhou, perdeu, timeout}, 0);
        reset = 1'b1;
        @(negedge clock);
        // T2: rounds 0 and 1
        start();
        chk("lat_edge1", esperando, 0);
        @(negedge clock);
        chk("lat_edge2", esperando, 0);
        @(negedge clock);
        chk("lat_edge3", esperando, 1);
        move(4'hA);
        chk("t2_fim0", fim_rodada, 1);
        chk("t2_rodada1", rodada, 1);
        play_round(1);
        chk("t2_fim1", fim_rodada, 1);
        chk("t2_rodada2", rodada, 2);
        // T3: wrong third move in round 2
        wait_esp(); move(4'hA);
        wait_esp(); move(4'hB);
        wait_esp(); move(4'h9);
        chk("t3_perdeu", perdeu, 1);
        chk("t3_timeout", timeout, 0);
        chk("t3_rodada", rodada, 2);
        // T4: timeout, then a strobe on the final count
        start();
        wait_esp();
        repeat (TIMEOUT_CYC - 1) @(negedge clock);
        chk("t4_not_yet", perdeu, 0);
        @(negedge clock);
        chk("t4_perdeu", perdeu, 1);
        chk("t4_timeout", timeout, 1);
        start();
        wait_esp();
        repeat (TIMEOUT_CYC - 1) @(negedge clock);
        move(4'hA);
        chk("t4_last_fim", fim_rodada, 1);
        chk("t4_last_perdeu", perdeu, 0);
        wait_esp();
        repeat (TIMEOUT_CYC - 1) @(negedge clock);
        move(4'hA);
        wait_esp(); move(4'hB);
        chk("t4_rodada2", rodada, 2);
        play_round(2);
        chk("t1_rodada3", rodada, 3);
        // T1: asynchronous reset in the middle of ESPERA
        wait_esp();
        chk("t1_esperando", esperando, 1);
        #2 reset = 1'b0;
        #1 chk("t1_async_clear", {rom_address, esperando, rodada, fim_rodada, ganhou, perdeu, timeout}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t1_idle", {rom_address, esperando, rodada}, 0);
        start();
        @(negedge clock);
        @(negedge clock);
        chk("t1_lat", esperando, 1);
        chk("t1_addr", rom_address, 0);
        // T5: full game to a win
        for (int r = 0; r <= LAST_ROUND; r++) play_round(r);
        chk("t5_ganhou", ganhou, 1);
        chk("t5_no_fim", fim_rodada, 0);
        chk("t5_rodada", rodada, LAST_ROUND);
        repeat (3) @(negedge clock);
        chk("t5_held", ganhou, 1);
        // T6: ignored strobes and ignored iniciar, after restarting from GANHOU
        start();
        chk("t5_restart_ganhou", ganhou, 0);
        chk("t5_restart_rodada", rodada, 0);
        jogada       = 4'h5;
        jogada_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        jogada_valid = 1'b0;
        chk("t6_esperando", esperando, 1);
        chk("t6_perdeu", perdeu, 0);
        iniciar = 1'b1;
        repeat (3) @(negedge clock);
        iniciar = 1'b0;
        chk("t6_still_wait", esperando, 1);
        move(4'hA);
        chk("t6_fim", fim_rodada, 1);
        chk("t6_rodada", rodada, 1);
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
